// File: rtl/multich_trigger_capture.sv
`default_nettype none
// ============================================================================
// multich_trigger_capture
// Multi-channel circular-buffer capture around a trigger, frozen for readout.
// Rev 1.0
// ============================================================================
module multich_trigger_capture #(
  parameter int NCH     = 2,
  parameter int DW      = 14,
  parameter int DEPTH   = 1000,
  parameter int AW      = $clog2(DEPTH),
  parameter int CW      = (NCH > 1 ? $clog2(NCH) : 1),
  parameter int TIMEOUT = 50000000
) (
  input  logic              sys_clk,
  input  logic              reset_n,
  input  logic [NCH*DW-1:0] adc_data,
  input  logic              arm,
  input  logic              abort,
  input  logic [CW-1:0]     trig_src,
  input  logic              trig_slope,
  input  logic [DW-1:0]     trig_level,
  input  logic [AW-1:0]     pre_samples,
  input  logic [1:0]        trig_mode,
  input  logic [CW-1:0]     rd_ch,
  input  logic [AW-1:0]     rd_addr,
  output logic [DW-1:0]     rd_data,
  output logic              busy,
  output logic              done,
  output logic              triggered,
  output logic [15:0]       wave_count
);

  localparam int            IW          = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int            TW          = $clog2(TIMEOUT + 1);
  localparam logic [AW-1:0] c_last      = AW'(DEPTH - 1);
  localparam logic [AW:0]   c_depth_ext = (AW+1)'(DEPTH);
  localparam logic [TW-1:0] c_timeout   = TW'(TIMEOUT);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_PRETRIG = 3'd1,
    S_ARMED   = 3'd2,
    S_POST    = 3'd3,
    S_DONE    = 3'd4
  } state_e;

  state_e          state_q;
  logic [DW-1:0]   cur_q  [NCH];
  logic [DW-1:0]   prev_q [NCH];
  logic [AW-1:0]   wr_ptr_q, start_ptr_q, cnt_q, pre_q;
  logic [TW-1:0]   tmo_q;
  logic [CW-1:0]   src_q;
  logic            slope_q;
  logic [DW-1:0]   level_q;
  logic [1:0]      mode_q;
  logic [DW-1:0]   rd_data_q;
  logic            busy_q, done_q, triggered_q;
  logic [15:0]     wave_count_q;

  logic            w_src_ok, w_rd_ch_ok, w_rd_addr_ok;
  logic [AW-1:0]   w_pre_clamp;
  logic [CW-1:0]   w_sel;
  logic [DW-1:0]   w_sel_cur, w_sel_prev;
  logic            w_rise, w_fall, w_fire;
  logic            w_wr_en;
  logic [AW-1:0]   w_wr_next, w_start, w_post;
  logic [AW:0]     w_rd_sum;
  logic [AW-1:0]   w_rd_idx;
  logic [DW-1:0]   w_ch_word [NCH];
  logic [DW-1:0]   w_rd_word;

  // Range guards collapse to constants when the field exactly covers its range.
  if (NCH == (1 << CW)) begin : g_ch_full
    assign w_src_ok   = 1'b1;
    assign w_rd_ch_ok = 1'b1;
  end else begin : g_ch_part
    assign w_src_ok   = (src_q < CW'(NCH));
    assign w_rd_ch_ok = (rd_ch < CW'(NCH));
  end

  if (DEPTH == (1 << AW)) begin : g_addr_full
    assign w_pre_clamp  = pre_samples;
    assign w_rd_addr_ok = 1'b1;
  end else begin : g_addr_part
    assign w_pre_clamp  = (pre_samples > c_last) ? c_last : pre_samples;
    assign w_rd_addr_ok = (rd_addr < AW'(DEPTH));
  end

  assign w_sel      = w_src_ok ? src_q : '0;
  assign w_sel_cur  = cur_q[w_sel];
  assign w_sel_prev = prev_q[w_sel];
  assign w_rise     = (w_sel_prev < level_q) && (w_sel_cur >= level_q);
  assign w_fall     = (w_sel_prev > level_q) && (w_sel_cur <= level_q);

  always_comb begin
    w_fire = slope_q ? w_fall : w_rise;
    if (mode_q == 2'd2 && tmo_q == '0)      w_fire = 1'b1;
    if (mode_q == 2'd1 && tmo_q == c_timeout) w_fire = 1'b1;
  end

  assign w_wr_en   = (state_q == S_PRETRIG) || (state_q == S_ARMED) || (state_q == S_POST);
  assign w_wr_next = (wr_ptr_q == c_last) ? '0 : wr_ptr_q + AW'(1);
  // When DEPTH is a power of two the AW-bit wraparound already gives the modulo.
  assign w_start   = (wr_ptr_q >= pre_q) ? (wr_ptr_q - pre_q)
                                         : (wr_ptr_q + AW'(DEPTH) - pre_q);
  assign w_post    = c_last - pre_q;

  assign w_rd_sum  = {1'b0, start_ptr_q} + {1'b0, rd_addr};
  assign w_rd_idx  = (w_rd_sum >= c_depth_ext) ? AW'(w_rd_sum - c_depth_ext) : AW'(w_rd_sum);
  assign w_rd_word = w_ch_word[rd_ch];

  for (genvar c = 0; c < NCH; c++) begin : g_ch
    logic [DW-1:0] mem [DEPTH];

    always_ff @(posedge sys_clk) begin
      if (w_wr_en) mem[IW'(wr_ptr_q)] <= cur_q[c];
    end

    assign w_ch_word[c] = mem[IW'(w_rd_idx)];
  end

  always_ff @(posedge sys_clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int c = 0; c < NCH; c++) begin
        cur_q[c]  <= '0;
        prev_q[c] <= '0;
      end
    end else begin
      for (int c = 0; c < NCH; c++) begin
        cur_q[c]  <= adc_data[c*DW +: DW];
        prev_q[c] <= cur_q[c];
      end
    end
  end

  always_ff @(posedge sys_clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= S_IDLE;
      wr_ptr_q     <= '0;
      start_ptr_q  <= '0;
      cnt_q        <= '0;
      pre_q        <= '0;
      tmo_q        <= '0;
      src_q        <= '0;
      slope_q      <= 1'b0;
      level_q      <= '0;
      mode_q       <= '0;
      rd_data_q    <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      triggered_q  <= 1'b0;
      wave_count_q <= '0;
    end else begin
      rd_data_q <= (done_q && w_rd_ch_ok && w_rd_addr_ok) ? w_rd_word : '0;
      if (abort) begin
        state_q     <= S_IDLE;
        busy_q      <= 1'b0;
        done_q      <= 1'b0;
        triggered_q <= 1'b0;
      end else begin
        case (state_q)
          S_IDLE, S_DONE: begin
            if (arm) begin
              src_q       <= trig_src;
              slope_q     <= trig_slope;
              level_q     <= trig_level;
              mode_q      <= trig_mode;
              pre_q       <= w_pre_clamp;
              wr_ptr_q    <= '0;
              cnt_q       <= '0;
              tmo_q       <= '0;
              done_q      <= 1'b0;
              triggered_q <= 1'b0;
              busy_q      <= 1'b1;
              state_q     <= (w_pre_clamp == '0) ? S_ARMED : S_PRETRIG;
            end
          end
          S_PRETRIG: begin
            wr_ptr_q <= w_wr_next;
            if (cnt_q == pre_q - AW'(1)) state_q <= S_ARMED;
            else                         cnt_q   <= cnt_q + AW'(1);
          end
          S_ARMED: begin
            wr_ptr_q <= w_wr_next;
            if (w_fire) begin
              start_ptr_q <= w_start;
              triggered_q <= 1'b1;
              cnt_q       <= '0;
              if (w_post == '0) begin
                state_q      <= S_DONE;
                busy_q       <= 1'b0;
                done_q       <= 1'b1;
                wave_count_q <= wave_count_q + 16'd1;
              end else begin
                state_q <= S_POST;
              end
            end else if (tmo_q != c_timeout) begin
              tmo_q <= tmo_q + TW'(1);
            end
          end
          S_POST: begin
            wr_ptr_q <= w_wr_next;
            if (cnt_q == w_post - AW'(1)) begin
              state_q      <= S_DONE;
              busy_q       <= 1'b0;
              done_q       <= 1'b1;
              wave_count_q <= wave_count_q + 16'd1;
            end else begin
              cnt_q <= cnt_q + AW'(1);
            end
          end
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

  assign rd_data    = rd_data_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign triggered  = triggered_q;
  assign wave_count = wave_count_q;

endmodule
`default_nettype wire

// File: tb/tb_multich_trigger_capture.sv
`default_nettype none
// ============================================================================
// tb_multich_trigger_capture
// Directed self-checking bench: NCH=2, DEPTH=16, AW=5, TIMEOUT=32.
// Rev 1.0
// ============================================================================
module tb_multich_trigger_capture;

  logic        sys_clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [27:0] adc_data;
  logic        arm = 1'b0, abort = 1'b0;
  logic        trig_src = 1'b0, trig_slope = 1'b0;
  logic [13:0] trig_level = '0;
  logic [4:0]  pre_samples = '0;
  logic [1:0]  trig_mode = '0;
  logic        rd_ch = 1'b0;
  logic [4:0]  rd_addr = '0;
  logic [13:0] rd_data;
  logic        busy, done, triggered;
  logic [15:0] wave_count;

  logic [13:0] ch0_v = '0, ch1_v = '0;
  int          inc0 = 0, inc1 = 0;
  int          checks = 0, failures = 0;

  assign adc_data = {ch1_v, ch0_v};

  multich_trigger_capture #(
    .NCH(2), .DW(14), .DEPTH(16), .AW(5), .CW(1), .TIMEOUT(32)
  ) dut (
    .sys_clk(sys_clk), .reset_n(reset_n), .adc_data(adc_data),
    .arm(arm), .abort(abort), .trig_src(trig_src), .trig_slope(trig_slope),
    .trig_level(trig_level), .pre_samples(pre_samples), .trig_mode(trig_mode),
    .rd_ch(rd_ch), .rd_addr(rd_addr), .rd_data(rd_data), .busy(busy),
    .done(done), .triggered(triggered), .wave_count(wave_count)
  );

  always #5 sys_clk = ~sys_clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Inputs advance 1 time unit after each rising edge.
  task automatic tick();
    @(posedge sys_clk);
    #1;
    ch0_v = ch0_v + 14'(inc0);
    ch1_v = ch1_v + 14'(inc1);
  endtask

  task automatic arm_pulse();
    arm = 1'b1;
    tick();
    arm = 1'b0;
  endtask

  task automatic configure(input logic src, input logic slope, input logic [13:0] lvl,
                           input logic [4:0] pre, input logic [1:0] mode);
    trig_src = src; trig_slope = slope; trig_level = lvl;
    pre_samples = pre; trig_mode = mode;
  endtask

  task automatic set_inputs(input logic [13:0] v0, input int i0, input logic [13:0] v1, input int i1);
    ch0_v = v0; inc0 = i0; ch1_v = v1; inc1 = i1;
  endtask

  task automatic wait_done(input int bound, output int n);
    n = 0;
    while (!done && n < bound) begin
      tick();
      n++;
    end
  endtask

  task automatic do_read(input logic ch, input logic [4:0] addr, output logic [13:0] d);
    rd_ch = ch; rd_addr = addr;
    tick();
    d = rd_data;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    tick(); tick();
    reset_n = 1'b1;
    tick();
    checks++; if (busy !== 1'b0)      begin failures++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++; if (done !== 1'b0)      begin failures++; $display("FAIL reset_done: got %b want 0", done); end
    checks++; if (triggered !== 1'b0) begin failures++; $display("FAIL reset_trig: got %b want 0", triggered); end
    checks++; if (wave_count !== 16'd0) begin failures++; $display("FAIL reset_wave: got %0d want 0", wave_count); end
    checks++; if (rd_data !== 14'd0)  begin failures++; $display("FAIL reset_rd: got %0d want 0", rd_data); end
  endtask

  task automatic test_normal_capture();
    int n;
    logic [13:0] d;
    configure(1'b0, 1'b0, 14'd100, 5'd4, 2'd0);
    set_inputs(14'd0, 1, 14'd0, 0);
    tick(); tick();
    arm_pulse();
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL norm_busy: got %b want 1", busy); end
    wait_done(300, n);
    checks++; if (done !== 1'b1) begin failures++; $display("FAIL norm_done: got %b want 1 after %0d cycles", done, n); end
    checks++; if (triggered !== 1'b1 || busy !== 1'b0) begin failures++; $display("FAIL norm_flags: got trig=%b busy=%b want 1 0", triggered, busy); end
    checks++; if (wave_count !== 16'd1) begin failures++; $display("FAIL norm_wave: got %0d want 1", wave_count); end
    do_read(1'b0, 5'd4, d);
    checks++; if (d !== 14'd100) begin failures++; $display("FAIL norm_addr4: got %0d want 100", d); end
    rd_addr = 5'd0;
    #2;
    checks++; if (rd_data !== 14'd100) begin failures++; $display("FAIL norm_latency: got %0d want 100 before edge", rd_data); end
    tick();
    checks++; if (rd_data !== 14'd96) begin failures++; $display("FAIL norm_addr0: got %0d want 96", rd_data); end
    do_read(1'b0, 5'd15, d);
    checks++; if (d !== 14'd111) begin failures++; $display("FAIL norm_addr15: got %0d want 111", d); end
    do_read(1'b1, 5'd4, d);
    checks++; if (d !== 14'd0) begin failures++; $display("FAIL norm_ch1: got %0d want 0", d); end
  endtask

  task automatic test_channel_slope();
    int n;
    logic [13:0] d;
    configure(1'b1, 1'b1, 14'd50, 5'd4, 2'd0);
    set_inputs(14'd30, 1, 14'd80, -1);
    tick(); tick();
    arm_pulse();
    wait_done(300, n);
    checks++; if (done !== 1'b1 || wave_count !== 16'd2) begin failures++; $display("FAIL chsl_done: got done=%b wave=%0d want 1 2", done, wave_count); end
    do_read(1'b1, 5'd4, d);
    checks++; if (d !== 14'd50) begin failures++; $display("FAIL chsl_ch1_addr4: got %0d want 50", d); end
    do_read(1'b1, 5'd0, d);
    checks++; if (d !== 14'd54) begin failures++; $display("FAIL chsl_ch1_addr0: got %0d want 54", d); end
    do_read(1'b1, 5'd15, d);
    checks++; if (d !== 14'd39) begin failures++; $display("FAIL chsl_ch1_addr15: got %0d want 39", d); end
    do_read(1'b0, 5'd4, d);
    checks++; if (d !== 14'd60) begin failures++; $display("FAIL chsl_ch0_addr4: got %0d want 60", d); end
  endtask

  task automatic test_auto_force();
    int n;
    configure(1'b0, 1'b0, 14'd100, 5'd4, 2'd1);
    set_inputs(14'd0, 0, 14'd0, 0);
    tick(); tick();
    arm_pulse();
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL auto_busy: got %b want 1", busy); end
    wait_done(200, n);
    checks++; if (n !== 48) begin failures++; $display("FAIL auto_cycles: got %0d want 48", n); end
    checks++; if (triggered !== 1'b1 || wave_count !== 16'd3) begin failures++; $display("FAIL auto_flags: got trig=%b wave=%0d want 1 3", triggered, wave_count); end
    trig_mode = 2'd2;
    arm_pulse();
    checks++; if (done !== 1'b0 || triggered !== 1'b0) begin failures++; $display("FAIL force_rearm: got done=%b trig=%b want 0 0", done, triggered); end
    wait_done(200, n);
    checks++; if (n !== 16) begin failures++; $display("FAIL force_cycles: got %0d want 16", n); end
    checks++; if (wave_count !== 16'd4) begin failures++; $display("FAIL force_wave: got %0d want 4", wave_count); end
  endtask

  task automatic test_wrap_clamp();
    int n;
    logic [13:0] d;
    configure(1'b0, 1'b0, 14'd100, 5'd20, 2'd0);
    set_inputs(14'd0, 1, 14'd0, 0);
    tick(); tick();
    arm_pulse();
    n = 0;
    while (!triggered && n < 300) begin
      tick();
      n++;
    end
    checks++; if (triggered !== 1'b1 || done !== 1'b1) begin failures++; $display("FAIL clamp_same_cycle: got trig=%b done=%b want 1 1", triggered, done); end
    checks++; if (wave_count !== 16'd5) begin failures++; $display("FAIL clamp_wave: got %0d want 5", wave_count); end
    do_read(1'b0, 5'd15, d);
    checks++; if (d !== 14'd100) begin failures++; $display("FAIL clamp_addr15: got %0d want 100", d); end
    do_read(1'b0, 5'd0, d);
    checks++; if (d !== 14'd85) begin failures++; $display("FAIL clamp_addr0: got %0d want 85", d); end
    do_read(1'b0, 5'd14, d);
    checks++; if (d !== 14'd99) begin failures++; $display("FAIL clamp_addr14: got %0d want 99", d); end
    do_read(1'b0, 5'd16, d);
    checks++; if (d !== 14'd0) begin failures++; $display("FAIL clamp_addr16: got %0d want 0", d); end
    do_read(1'b0, 5'd31, d);
    checks++; if (d !== 14'd0) begin failures++; $display("FAIL clamp_addr31: got %0d want 0", d); end
  endtask

  task automatic test_abort_arm_busy();
    int n;
    logic [13:0] d;
    configure(1'b0, 1'b0, 14'd100, 5'd4, 2'd0);
    set_inputs(14'd0, 1, 14'd0, 0);
    tick(); tick();
    arm_pulse();
    n = 0;
    while (!triggered && n < 300) begin
      tick();
      n++;
    end
    checks++; if (triggered !== 1'b1 || busy !== 1'b1 || done !== 1'b0) begin failures++; $display("FAIL abort_post: got trig=%b busy=%b done=%b want 1 1 0", triggered, busy, done); end
    arm_pulse();
    checks++; if (triggered !== 1'b1 || busy !== 1'b1) begin failures++; $display("FAIL arm_ignored: got trig=%b busy=%b want 1 1", triggered, busy); end
    abort = 1'b1; arm = 1'b1;
    tick();
    abort = 1'b0; arm = 1'b0;
    checks++; if (busy !== 1'b0 || done !== 1'b0 || triggered !== 1'b0) begin failures++; $display("FAIL abort_flags: got busy=%b done=%b trig=%b want 0 0 0", busy, done, triggered); end
    checks++; if (wave_count !== 16'd5) begin failures++; $display("FAIL abort_wave: got %0d want 5", wave_count); end
    do_read(1'b0, 5'd4, d);
    checks++; if (d !== 14'd0) begin failures++; $display("FAIL abort_rd: got %0d want 0", d); end
    tick(); tick();
    checks++; if (busy !== 1'b0 || done !== 1'b0) begin failures++; $display("FAIL abort_idle: got busy=%b done=%b want 0 0", busy, done); end
  endtask

  task automatic test_reset_mid();
    configure(1'b0, 1'b0, 14'd10000, 5'd4, 2'd0);
    set_inputs(14'd0, 0, 14'd0, 0);
    arm_pulse();
    for (int i = 0; i < 8; i++) tick();
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL rstmid_armed: got busy=%b want 1", busy); end
    #2;
    reset_n = 1'b0;
    #1;
    checks++; if (busy !== 1'b0)        begin failures++; $display("FAIL rstmid_busy: got %b want 0", busy); end
    checks++; if (done !== 1'b0 || triggered !== 1'b0) begin failures++; $display("FAIL rstmid_flags: got done=%b trig=%b want 0 0", done, triggered); end
    checks++; if (wave_count !== 16'd0) begin failures++; $display("FAIL rstmid_wave: got %0d want 0", wave_count); end
    checks++; if (rd_data !== 14'd0)    begin failures++; $display("FAIL rstmid_rd: got %0d want 0", rd_data); end
    reset_n = 1'b1;
    tick();
  endtask

  task automatic test_counter_wrap();
    int n;
    configure(1'b0, 1'b0, 14'd100, 5'd4, 2'd2);
    force dut.wave_count_q = 16'hFFFF;
    #1;
    release dut.wave_count_q;
    checks++; if (wave_count !== 16'hFFFF) begin failures++; $display("FAIL wrap_preload: got %0d want 65535", wave_count); end
    tick();
    arm_pulse();
    wait_done(100, n);
    checks++; if (done !== 1'b1) begin failures++; $display("FAIL wrap_done: got %b want 1", done); end
    checks++; if (wave_count !== 16'd0) begin failures++; $display("FAIL wrap_count: got %0d want 0", wave_count); end
  endtask

  initial begin
    test_reset();
    test_normal_capture();
    test_channel_slope();
    test_auto_force();
    test_wrap_clamp();
    test_abort_arm_busy();
    test_reset_mid();
    test_counter_wrap();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/multich_trigger_capture.md
Name: multich_trigger_capture

Overview:
- Parametrised successor to the fixed 2-channel, 1000-sample waveform capture path.
- Captures DEPTH samples per channel into circular buffers around a trigger event, then freezes the buffers for readout by the UART side.
- Adds a selectable trigger channel, slope, level, pre-trigger depth, auto/force modes, abort and random-access readout.
- Sits between the adcSync outputs and the UART handler, in the sys_clk domain.

Parameters:
- NCH, 2, number of ADC channels captured in parallel.
- DW, 14, sample width in bits, unsigned offset-binary.
- DEPTH, 1000, samples stored per channel per record.
- AW, $clog2(DEPTH), address width.
- CW, (NCH>1 ? $clog2(NCH) : 1), channel-select width.
- TIMEOUT, 50000000, ARMED cycles before auto mode forces a trigger.

Ports:
- sys_clk  in  1  capture and readout clock.
- reset_n  in  1  asynchronous, active-low reset.
- adc_data  in  NCH*DW  channel i at [i*DW +: DW], one sample per cycle.
- arm  in  1  single-cycle pulse; starts a capture.
- abort  in  1  single-cycle pulse; cancels a capture.
- trig_src  in  CW  trigger channel; values >= NCH select channel 0.
- trig_slope  in  1  0 = rising, 1 = falling.
- trig_level  in  DW  threshold.
- pre_samples  in  AW  pre-trigger sample count.
- trig_mode  in  2  0 = normal, 1 = auto, 2 = force, 3 = normal.
- rd_ch  in  CW  readout channel.
- rd_addr  in  AW  logical index; 0 is the oldest sample.
- rd_data  out  DW  registered readout data.
- busy  out  1  capture in progress (PRETRIG, ARMED or POST).
- done  out  1  record complete and frozen.
- triggered  out  1  trigger accepted in the current capture.
- wave_count  out  16  completed-record counter.

Behaviour:
- Reset: state IDLE; pointers, counters, rd_data, busy, done, triggered and wave_count all 0. Buffer contents are undefined.
- Input stage:
  - adc_data is registered into cur; cur is copied into prev every cycle in all states.
  - Rising trigger: prev < level && cur >= level on the selected channel.
  - Falling trigger: prev > level && cur <= level.
- Configuration latch: on arm accepted in IDLE or DONE, latch trig_src, trig_slope, trig_level, trig_mode and pre = min(pre_samples, DEPTH-1). Clear wr_ptr, done and triggered. arm is ignored while busy.
- Writes: in PRETRIG, ARMED and POST, write cur of every channel to mem[ch][wr_ptr]. wr_ptr wraps DEPTH-1 -> 0.
- State machine:
  - IDLE/DONE -> PRETRIG on arm; if pre == 0, go directly to ARMED.
  - PRETRIG: lasts exactly pre cycles; triggers are ignored; then -> ARMED.
  - ARMED: on trigger, or on the first ARMED cycle in force mode, or after TIMEOUT ARMED cycles in auto mode:
    - start_ptr = (wr_ptr - pre) mod DEPTH; the sample written this cycle is logical index pre;
    - triggered = 1;
    - post = DEPTH-1-pre;
    - -> POST, or -> DONE if post == 0.
  - POST: write post further samples, then -> DONE.
  - DONE: done = 1; no writes; wave_count += 1 on entry, wrapping at 0xFFFF -> 0.
- abort: any state -> IDLE next cycle. done and triggered are cleared; wave_count is unchanged. abort wins over a simultaneous arm.
- Readout:
  - rd_data is registered, 1-cycle latency: mem[rd_ch][(start_ptr+rd_addr) mod DEPTH].
  - rd_data = 0 when done == 0, rd_addr >= DEPTH or rd_ch >= NCH.
- Reset mid-capture: immediate return to the reset values; no partial record is flagged.

Test Plan:
- Normal capture: NCH=2, DEPTH=16, pre=4, rising, level=100; ch0 ramps +1/cycle from 0. Required: done after 16 written samples; rd ch0 addr4 = 100, addr0 = 96, addr15 = 111; rd_data valid 1 cycle after address; wave_count = 1.
- Channel and slope selection: trig_src=1, falling, level=50; ch0 crosses 50 rising, ch1 crosses falling 60 -> 40. Required: trigger only on ch1; logical index pre = first ch1 sample <= 50.
- Auto mode: TIMEOUT=32, constant input 0, pre=4, DEPTH=16. Required: done exactly 4+32+12 cycles after the first write; force mode (trig_mode=2) gives done after 4+12 cycles.
- Wrap and clamp: pre_samples=20 with DEPTH=16. Required: pre clamps to 15, post = 0, DONE on the trigger cycle; logical addresses map across the physical wrap correctly.
- Abort and reset: abort in POST -> IDLE, done=0, wave_count unchanged; arm during busy is ignored; reset_n low in ARMED forces all outputs to 0 asynchronously.
- Counter wrap: preload via 65535 captures (or force) -> the next completed record gives wave_count = 0.
